// File: rtl/inst_mem_wait.sv
// Writable instruction memory with a req/ready fetch handshake and a programmable
// number of wait states; bad fetch addresses complete early with an AddrErr pulse.
//
// state  | meaning
// S_IDLE | no fetch outstanding, outputs hold the last result
// S_WAIT | fetch accepted, wait-state down-counter running, Busy=1
// S_DONE | Ready/AddrErr pulse cycle; a new Req here starts the next fetch
module inst_mem_wait #(
  parameter int          DEPTH_LOG2  = 5,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  Req,
  input  logic [31:0]           Addr,
  output logic [31:0]           Inst,
  output logic                  Ready,
  output logic                  AddrErr,
  output logic                  Busy,
  input  logic                  Ld_we,
  input  logic [DEPTH_LOG2-1:0] Ld_addr,
  input  logic [31:0]           Ld_data
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           inst_q, inst_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_bad;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_data;

  assign req_idx = Addr[DEPTH_LOG2+1:2];
  assign req_bad = (Addr[1:0] != 2'b00) || ((Addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  // A fetch reads with the latched index from WAIT, or straight from Addr when
  // there are no wait states; a same-edge loader write to that word wins.
  assign rd_idx  = (state_q == S_WAIT) ? idx_q : req_idx;
  assign rd_data = (Ld_we && (Ld_addr == rd_idx)) ? Ld_data : mem_q[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    inst_d  = inst_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Req) begin
          idx_d = req_idx;
          cnt_d = WS_LOAD;
          if (req_bad) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
            inst_d  = NOP_WORD;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            inst_d  = rd_data;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          inst_d  = rd_data;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      inst_q  <= NOP_WORD;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inst_q  <= inst_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Program storage is deliberately not reset; the loader fills it at run time.
  always_ff @(posedge Clk) begin
    if (Ld_we) mem_q[Ld_addr] <= Ld_data;
  end

  assign Inst    = inst_q;
  assign Ready   = ready_q;
  assign AddrErr = err_q;
  assign Busy    = (state_q == S_WAIT);

endmodule

// File: tb/tb_inst_mem_wait.sv
// Bench for inst_mem_wait: a 2-wait-state instance and a 0-wait-state instance share
// the loader, checked against a word-array model of the fetch rules.
module tb_inst_mem_wait;
  localparam int          DL2 = 5;
  localparam int          WS  = 2;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0, Clrn = 1'b0;
  logic        Req = 1'b0, Req0 = 1'b0;
  logic [31:0] Addr = '0, Addr0 = '0;
  logic [31:0] Inst, Inst0;
  logic        Ready, Ready0, AddrErr, AddrErr0, Busy, Busy0;
  logic        Ld_we = 1'b0;
  logic [4:0]  Ld_addr = '0;
  logic [31:0] Ld_data = '0;

  logic [31:0] model_mem [32];
  int checks = 0, errors = 0;

  inst_mem_wait #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Clrn(Clrn), .Req(Req), .Addr(Addr), .Inst(Inst), .Ready(Ready),
    .AddrErr(AddrErr), .Busy(Busy), .Ld_we(Ld_we), .Ld_addr(Ld_addr), .Ld_data(Ld_data));

  inst_mem_wait #(.DEPTH_LOG2(DL2), .WAIT_STATES(0), .NOP_WORD(NOP)) dut0 (
    .Clk(Clk), .Clrn(Clrn), .Req(Req0), .Addr(Addr0), .Inst(Inst0), .Ready(Ready0),
    .AddrErr(AddrErr0), .Busy(Busy0), .Ld_we(Ld_we), .Ld_addr(Ld_addr), .Ld_data(Ld_data));

  always #5 Clk = ~Clk;

  function automatic logic ref_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * (1 << DL2)));
  endfunction

  function automatic logic [31:0] ref_inst(input logic [31:0] a);
    return ref_bad(a) ? NOP : model_mem[a / 4];
  endfunction

  task automatic load_word(input int idx, input logic [31:0] d);
    @(negedge Clk);
    Ld_we = 1'b1; Ld_addr = 5'(idx); Ld_data = d;
    @(posedge Clk); #1;
    Ld_we = 1'b0;
    model_mem[idx] = d;
  endtask

  // Issues one fetch on the WS instance and reports what it observed (lat=-1: timeout).
  task automatic do_fetch(input logic [31:0] a, output logic [31:0] inst, output logic err,
                          output int lat, output int busy_n, output logic held);
    @(negedge Clk);
    Req = 1'b1; Addr = a;
    @(posedge Clk); #1;
    Req = 1'b0; Addr = $urandom;
    lat = 1; busy_n = 0; err = 1'b0; inst = '0; held = 1'b0;
    while (!Ready && lat < 20) begin
      if (Busy) busy_n++;
      @(posedge Clk); #1;
      lat++;
    end
    if (!Ready) lat = -1;
    else begin
      inst = Inst; err = AddrErr;
      @(posedge Clk); #1;
      held = !Ready && (Inst === inst);
    end
  endtask

  task automatic test_reset;
    @(negedge Clk);
    checks++; if ({Inst, Ready, AddrErr, Busy} !== {NOP, 3'b000}) begin errors++;
      $display("FAIL reset_state got inst=%h rdy=%b err=%b busy=%b", Inst, Ready, AddrErr, Busy); end
    checks++; if ({Inst0, Ready0, AddrErr0, Busy0} !== {NOP, 3'b000}) begin errors++;
      $display("FAIL reset_state0 got inst=%h rdy=%b err=%b busy=%b", Inst0, Ready0, AddrErr0, Busy0); end
    Clrn = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] inst; logic err, held; int lat, bn;
    load_word(0, 32'h3c01_1111);
    load_word(5, 32'h0022_2824);
    do_fetch(32'h14, inst, err, lat, bn, held);
    checks++; if (inst !== ref_inst(32'h14) || err !== 1'b0) begin errors++;
      $display("FAIL basic_data got %h/%b exp %h/0", inst, err, ref_inst(32'h14)); end
    checks++; if (lat !== WS + 1 || bn !== WS) begin errors++;
      $display("FAIL basic_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", lat, bn, WS + 1, WS); end
    checks++; if (held !== 1'b1) begin errors++;
      $display("FAIL basic_hold got %b exp 1", held); end
  endtask

  task automatic test_addr_err;
    logic [31:0] inst; logic err, held; int lat, bn;
    do_fetch(32'h16, inst, err, lat, bn, held);
    checks++; if (inst !== NOP || err !== 1'b1 || lat !== 1 || bn !== 0) begin errors++;
      $display("FAIL misaligned got inst=%h err=%b lat=%0d busy=%0d exp %h 1 1 0", inst, err, lat, bn, NOP); end
    do_fetch(32'h80, inst, err, lat, bn, held);
    checks++; if (inst !== NOP || err !== 1'b1 || lat !== 1) begin errors++;
      $display("FAIL out_of_range got inst=%h err=%b lat=%0d exp %h 1 1", inst, err, lat, NOP); end
    do_fetch(32'h0, inst, err, lat, bn, held);
    checks++; if (inst !== 32'h3c01_1111 || err !== 1'b0 || lat !== WS + 1) begin errors++;
      $display("FAIL after_err got inst=%h err=%b lat=%0d exp 3c011111 0 %0d", inst, err, lat, WS + 1); end
  endtask

  task automatic test_collision;
    @(negedge Clk);
    Req = 1'b1; Addr = 32'h14;
    @(posedge Clk); #1;
    Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Ld_we = 1'b1; Ld_addr = 5'd5; Ld_data = 32'hDEAD_BEEF;
    Req0 = 1'b1; Addr0 = 32'h14;
    @(posedge Clk); #1;
    Ld_we = 1'b0; Req0 = 1'b0;
    model_mem[5] = 32'hDEAD_BEEF;
    checks++; if (Ready !== 1'b1 || Inst !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL collision got rdy=%b inst=%h exp 1 deadbeef", Ready, Inst); end
    checks++; if (Ready0 !== 1'b1 || Inst0 !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL collision0 got rdy=%b inst=%h exp 1 deadbeef", Ready0, Inst0); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    load_word(1, 32'h1111_0001);
    load_word(2, 32'h2222_0002);
    @(negedge Clk);
    Req0 = 1'b1; Addr0 = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if (i < 2) Addr0 = addrs[i + 1]; else Req0 = 1'b0;
      checks++; if (Ready0 !== 1'b1 || Inst0 !== ref_inst(addrs[i])) begin errors++;
        $display("FAIL b2b0_%0d got rdy=%b inst=%h exp 1 %h", i, Ready0, Inst0, ref_inst(addrs[i])); end
    end
    @(posedge Clk); #1;
    checks++; if (Ready0 !== 1'b0) begin errors++;
      $display("FAIL b2b0_end got rdy=%b exp 0", Ready0); end
    // Req held on the wait-state instance: one completion every WS+1 cycles, no bubble
    @(negedge Clk);
    Req = 1'b1; Addr = 32'h0;
    for (int i = 0; i < 2 * (WS + 1); i++) begin
      logic exp_rdy;
      @(posedge Clk); #1;
      exp_rdy = ((i + 1) % (WS + 1)) == 0;
      checks++; if (Ready !== exp_rdy || (exp_rdy && Inst !== model_mem[0])) begin errors++;
        $display("FAIL b2b_cycle%0d got rdy=%b inst=%h exp rdy=%b inst=%h", i, Ready, Inst, exp_rdy, model_mem[0]); end
    end
    Req = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_abort;
    logic [31:0] inst; logic err, held; int lat, bn;
    logic saw_ready;
    @(negedge Clk);
    Req = 1'b1; Addr = 32'h14;
    @(posedge Clk); #1;
    Req = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++;
      $display("FAIL abort_busy got %b exp 1", Busy); end
    #2 Clrn = 1'b0;
    #1;
    checks++; if ({Busy, Ready, AddrErr, Inst} !== {3'b000, NOP}) begin errors++;
      $display("FAIL abort_reset got busy=%b rdy=%b err=%b inst=%h", Busy, Ready, AddrErr, Inst); end
    @(negedge Clk);
    Clrn = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (Ready || Busy) saw_ready = 1'b1;
    end
    checks++; if (saw_ready !== 1'b0) begin errors++;
      $display("FAIL abort_no_ready got activity=%b exp 0", saw_ready); end
    do_fetch(32'h14, inst, err, lat, bn, held);
    checks++; if (inst !== ref_inst(32'h14) || err !== 1'b0 || lat !== WS + 1) begin errors++;
      $display("FAIL abort_refetch got inst=%h err=%b lat=%0d exp %h 0 %0d", inst, err, lat, ref_inst(32'h14), WS + 1); end
  endtask

  task automatic test_random;
    logic [31:0] a, inst; logic err, held; int lat, bn, kind;
    for (int i = 0; i < 32; i++) load_word(i, $urandom);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) load_word(int'($urandom_range(0, 31)), $urandom);
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      a = ($urandom_range(0, 31) * 4) | $urandom_range(1, 3);
      else if (kind == 1) a = $urandom | 32'h80;
      else if (kind == 2) a = 32'h7C;
      else                a = $urandom_range(0, 31) * 4;
      do_fetch(a, inst, err, lat, bn, held);
      checks++; if (inst !== ref_inst(a) || err !== ref_bad(a)) begin errors++;
        $display("FAIL rand_data addr=%h got %h/%b exp %h/%b", a, inst, err, ref_inst(a), ref_bad(a)); end
      checks++; if (lat !== (ref_bad(a) ? 1 : WS + 1) || bn !== (ref_bad(a) ? 0 : WS)) begin errors++;
        $display("FAIL rand_timing addr=%h got lat=%0d busy=%0d", a, lat, bn); end
      checks++; if (held !== 1'b1) begin errors++;
        $display("FAIL rand_hold addr=%h got %b exp 1", a, held); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_addr_err;
    test_collision;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end
endmodule
